// File: rtl/poly_fifo_reader.sv
// rtl/poly_fifo_reader.sv - sink-side drain engine for the polynomial RAM FIFO
// Optional feature: define POLY_RD_BITREV_EN for a bit-reversed bank sweep order.
module poly_fifo_reader #(
  parameter int ADDR_WIDTH    = 3,
  parameter int BIT_WIDTH     = 8,
  parameter int LINE_SIZE     = 2,
  parameter int RLWE_ID_WIDTH = 4,
  parameter int POLY_ID_WIDTH = 4,
  parameter int OPCODE_WIDTH  = 4,
  parameter int NUM_BEATS     = 2 ** (ADDR_WIDTH - 1)
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           empty,
  input  logic [RLWE_ID_WIDTH-1:0]       rlwe_id,
  input  logic [POLY_ID_WIDTH-1:0]       poly_id,
  input  logic [OPCODE_WIDTH-1:0]        opcode,
  input  logic [BIT_WIDTH*LINE_SIZE-1:0] dA,
  input  logic [BIT_WIDTH*LINE_SIZE-1:0] dB,
  output logic                           rd_finish,
  output logic [ADDR_WIDTH-1:0]          addrA,
  output logic [ADDR_WIDTH-1:0]          addrB,
  output logic                           rd_en,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [BIT_WIDTH*LINE_SIZE-1:0] out_dA,
  output logic [BIT_WIDTH*LINE_SIZE-1:0] out_dB,
  output logic                           out_first,
  output logic                           out_last,
  output logic [RLWE_ID_WIDTH-1:0]       out_rlwe_id,
  output logic [POLY_ID_WIDTH-1:0]       out_poly_id,
  output logic [OPCODE_WIDTH-1:0]        out_opcode,
  output logic                           busy
);

  localparam int KW = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [KW-1:0]         K_LAST   = KW'(NUM_BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] B_OFFSET = ADDR_WIDTH'(NUM_BEATS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_FINISH
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [KW-1:0]   k_q;
  logic [KW-1:0]   idx;
  logic            valid_q;
  logic            first_q;
  logic            last_q;
  logic            issue;
  logic            accept;
  logic            latch_hdr;

  // Map issue order to bank line index; the B half sits NUM_BEATS lines above A.
  function automatic logic [KW-1:0] sweep_idx(input logic [KW-1:0] k);
    logic [KW-1:0] r;
`ifdef POLY_RD_BITREV_EN
    for (int i = 0; i < KW; i++) begin
      r[i] = k[KW-1-i];
    end
`else
    r = k;
`endif
    return r;
  endfunction

  assign idx    = sweep_idx(k_q);
  assign accept = valid_q & out_ready;

  // State register; reset drops straight back to IDLE so the bank is released at once.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and FIFO handshake; a read is issued only when the output slot frees up.
  always_comb begin
    state_d   = state_q;
    rd_en     = 1'b0;
    rd_finish = 1'b1;
    issue     = 1'b0;
    latch_hdr = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          latch_hdr = 1'b1;
          state_d   = S_READ;
        end
      end
      S_READ: begin
        rd_finish = 1'b0;
        rd_en     = !valid_q || out_ready;
        issue     = rd_en;
        if (issue && (k_q == K_LAST)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // RAM is frozen (rd_en low) so the last beat stays on dA/dB until taken.
        rd_finish = 1'b0;
        if (accept) begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Header latch, beat counter and output-valid tracking for the registered beat flags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      k_q         <= '0;
      valid_q     <= 1'b0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      out_rlwe_id <= '0;
      out_poly_id <= '0;
      out_opcode  <= '0;
    end else begin
      if (latch_hdr) begin
        out_rlwe_id <= rlwe_id;
        out_poly_id <= poly_id;
        out_opcode  <= opcode;
        k_q         <= '0;
      end
      if (issue) begin
        valid_q <= 1'b1;
        first_q <= (k_q == '0);
        last_q  <= (k_q == K_LAST);
        k_q     <= k_q + KW'(1);
      end else if (accept) begin
        valid_q <= 1'b0;
        first_q <= 1'b0;
        last_q  <= 1'b0;
      end
    end
  end

  // Addresses are combinational from k so the RAM samples them in the issue cycle.
  assign addrA     = (state_q == S_READ) ? ADDR_WIDTH'(idx) : '0;
  assign addrB     = (state_q == S_READ) ? (ADDR_WIDTH'(idx) + B_OFFSET) : '0;
  assign out_valid = valid_q;
  assign out_first = first_q & valid_q;
  assign out_last  = last_q & valid_q;
  assign out_dA    = dA;
  assign out_dB    = dB;
  assign busy      = (state_q != S_IDLE);

endmodule
